// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
//
// Purpose:
//   Green-time scheduler for a four-approach intersection. Vehicle requests
//   are latched per approach, and right-of-way is granted round-robin. Every
//   handover passes through a yellow phase and then an all-red clearance
//   phase. Approach 0 is the home (main-road) approach and keeps green while
//   nobody else is waiting. An emergency preempt can cut a green short, which
//   ignores the minimum green, and it can hold a green indefinitely. All
//   phase timing is counted in tick pulses of 1 Hz.
//
// Parameters:
//   T_MIN_GREEN  minimum green, in ticks, before a normal handover
//   T_MAX_GREEN  green length, in ticks, after which handover is forced
//   T_YELLOW     yellow length in ticks (>= 1)
//   T_ALL_RED    all-red clearance length in ticks (>= 1)
//   CNT_W        phase timer width (must hold T_MAX_GREEN)
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   tick         one-clk pulse per second; the timer advances only on tick
//   req[3:0]     vehicle detector level per approach
//   emerg_valid  emergency preempt active (level)
//   emerg_id     approach requested by the emergency vehicle
//   green[3:0]   registered green lamps
//   yellow[3:0]  registered yellow lamps
//   red[3:0]     registered red lamps
//   cur_app      approach that owns right-of-way (green, or yellow while ending)
//   served[3:0]  one-clk pulse in the cycle an approach's green turns on
// -----------------------------------------------------------------------------
module intersection_phase_scheduler #(
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 60,
    parameter int T_YELLOW    = 5,
    parameter int T_ALL_RED   = 2,
    parameter int CNT_W       = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [3:0]       req,
    input  logic             emerg_valid,
    input  logic [1:0]       emerg_id,
    output logic [3:0]       green,
    output logic [3:0]       yellow,
    output logic [3:0]       red,
    output logic [1:0]       cur_app,
    output logic [3:0]       served
);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    // Timer thresholds sized to the timer so that comparisons are width-exact.
    localparam logic [CNT_W-1:0] L_MIN_GREEN = CNT_W'(T_MIN_GREEN);
    localparam logic [CNT_W-1:0] L_MAX_GREEN = CNT_W'(T_MAX_GREEN);
    localparam logic [CNT_W-1:0] L_YEL_LAST  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] L_AR_LAST   = CNT_W'(T_ALL_RED - 1);

    function automatic logic [3:0] f_onehot(input logic [1:0] a);
        return 4'b0001 << a;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             r_state;
    logic [1:0]         r_cur;
    logic [CNT_W-1:0]   r_timer;
    logic [3:0]         r_pend;
    logic [3:0]         r_green;
    logic [3:0]         r_yellow;
    logic [3:0]         r_red;
    logic [3:0]         r_served;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [1:0]         w_cur_nxt;
    logic [CNT_W-1:0]   w_timer_nxt;
    logic [3:0]         w_pend_nxt;
    logic [3:0]         w_green_nxt;
    logic [3:0]         w_yellow_nxt;
    logic [3:0]         w_red_nxt;
    logic [3:0]         w_served_nxt;

    logic               w_others;
    logic               w_emerg_cur;
    logic               w_emerg_other;
    logic               w_go_yellow;
    logic               w_grant;
    logic [1:0]         w_next_app;
    logic [1:0]         w_rr_app;
    logic               w_rr_found;
    logic [1:0]         w_rr_idx;
    logic [3:0]         w_pend_set;
    logic [3:0]         w_pend_clr;

    // Someone other than the current owner is waiting.
    assign w_others      = |(r_pend & ~f_onehot(r_cur));
    assign w_emerg_cur   = emerg_valid && (emerg_id == r_cur);
    assign w_emerg_other = emerg_valid && (emerg_id != r_cur);

    // Handover out of green: emergency elsewhere ignores minimum green; an
    // emergency for the owner suppresses both gap-out and max-out.
    assign w_go_yellow = w_emerg_other ||
                         (!w_emerg_cur && w_others &&
                          (((r_timer >= L_MIN_GREEN) && !req[r_cur]) ||
                           (r_timer >= L_MAX_GREEN)));

    // Round-robin search starting just after the current owner; the 2-bit
    // index wraps modulo 4 by construction.
    always_comb begin
        w_rr_app   = 2'd0;
        w_rr_found = 1'b0;
        w_rr_idx   = 2'd0;
        for (int k = 1; k < 4; k++) begin
            w_rr_idx = r_cur + 2'(k);
            if (!w_rr_found && r_pend[w_rr_idx]) begin
                w_rr_app   = w_rr_idx;
                w_rr_found = 1'b1;
            end
        end
    end

    // Emergency target first, then round-robin, else fall back to home.
    always_comb begin
        w_next_app = 2'd0;
        if (emerg_valid) begin
            w_next_app = emerg_id;
        end else if (w_rr_found) begin
            w_next_app = w_rr_app;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_grant     = 1'b0;

        case (r_state)
            ST_GREEN: begin
                if (w_go_yellow) begin
                    w_state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                // Emergencies do not shorten yellow.
                if (tick && (r_timer == L_YEL_LAST)) begin
                    w_state_nxt = ST_ALLRED;
                end
            end
            ST_ALLRED: begin
                if (tick && (r_timer == L_AR_LAST)) begin
                    w_state_nxt = ST_GREEN;
                    w_cur_nxt   = w_next_app;
                    w_grant     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_GREEN;
            end
        endcase

        // Timer restarts on every state entry and saturates at max green.
        w_timer_nxt = r_timer;
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end else if (tick && (r_timer < L_MAX_GREEN)) begin
            w_timer_nxt = r_timer + CNT_W'(1);
        end

        // The green owner does not latch its own request; the approach
        // entering green has its request cleared, and clear wins over set.
        w_pend_set = req & ((r_state == ST_GREEN) ? ~f_onehot(r_cur) : 4'b1111);
        w_pend_clr = w_grant ? f_onehot(w_cur_nxt) : 4'b0000;
        w_pend_nxt = (r_pend | w_pend_set) & ~w_pend_clr;

        // Lamps are decoded from the next state so they change on the same
        // edge as the FSM.
        w_green_nxt  = (w_state_nxt == ST_GREEN)  ? f_onehot(w_cur_nxt) : 4'b0000;
        w_yellow_nxt = (w_state_nxt == ST_YELLOW) ? f_onehot(w_cur_nxt) : 4'b0000;
        w_red_nxt    = ~(w_green_nxt | w_yellow_nxt);
        w_served_nxt = w_grant ? f_onehot(w_cur_nxt) : 4'b0000;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_GREEN;
            r_cur    <= 2'd0;
            r_timer  <= '0;
            r_pend   <= 4'b0000;
            r_green  <= 4'b0001;
            r_yellow <= 4'b0000;
            r_red    <= 4'b1110;
            r_served <= 4'b0000;
        end else begin
            r_state  <= w_state_nxt;
            r_cur    <= w_cur_nxt;
            r_timer  <= w_timer_nxt;
            r_pend   <= w_pend_nxt;
            r_green  <= w_green_nxt;
            r_yellow <= w_yellow_nxt;
            r_red    <= w_red_nxt;
            r_served <= w_served_nxt;
        end
    end

    assign green   = r_green;
    assign yellow  = r_yellow;
    assign red     = r_red;
    assign cur_app = r_cur;
    assign served  = r_served;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_phase_scheduler
//
// Directed bench for intersection_phase_scheduler with default parameters.
// One tick pulse is issued every three clocks. Expected lamp patterns and
// tick counts are hand-derived from the phase timing (10 min green, 60 max
// green, 5 yellow, 2 all-red).
// -----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] req;
    logic       emerg_valid;
    logic [1:0] emerg_id;
    logic [3:0] green;
    logic [3:0] yellow;
    logic [3:0] red;
    logic [1:0] cur_app;
    logic [3:0] served;

    int n_chk      = 0;
    int n_pass     = 0;
    int srv_pulses = 0;
    logic [3:0] srv_last = 4'b0000;
    int inv_bad    = 0;

    always #5 clk = ~clk;

    intersection_phase_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .req         (req),
        .emerg_valid (emerg_valid),
        .emerg_id    (emerg_id),
        .green       (green),
        .yellow      (yellow),
        .red         (red),
        .cur_app     (cur_app),
        .served      (served)
    );

    // Served-pulse log and lamp-invariant watch, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (served != 4'b0000) begin
                srv_pulses = srv_pulses + 1;
                srv_last   = served;
            end
            if (((green | yellow | red) != 4'hF) || ((green & yellow) != 0) ||
                ((green & red) != 0) || ((yellow & red) != 0) ||
                ($countones(~red) > 1)) begin
                inv_bad = inv_bad + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic tick1();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
    endtask

    task automatic do_reset();
        tick        = 1'b0;
        req         = 4'b0000;
        emerg_valid = 1'b0;
        emerg_id    = 2'd0;
        rst         = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic run_until_grant(input int max_t, output int nt);
        int s0;
        s0 = srv_pulses;
        nt = 0;
        while ((srv_pulses == s0) && (nt < max_t)) begin
            tick1();
            nt++;
        end
    endtask

    initial begin
        int bad;
        int s0;
        int nt;

        rst         = 1'b0;
        tick        = 1'b0;
        req         = 4'b0000;
        emerg_valid = 1'b0;
        emerg_id    = 2'd0;

        // Reset state, checked before any clock edge has occurred.
        #1 rst = 1'b1;
        #1;
        chk("rst_green",  {28'd0, green},   32'h1);
        chk("rst_yellow", {28'd0, yellow},  32'h0);
        chk("rst_red",    {28'd0, red},     32'hE);
        chk("rst_served", {28'd0, served},  32'h0);
        chk("rst_cur",    {30'd0, cur_app}, 32'h0);
        step();
        step();
        rst = 1'b0;
        step();

        // Idle: home approach keeps green with nobody waiting.
        bad = 0;
        s0  = srv_pulses;
        repeat (100) begin
            tick1();
            if ((green != 4'b0001) || (red != 4'b1110) || (yellow != 4'b0000)) bad++;
        end
        chk("idle_lamps",  bad, 0);
        chk("idle_served", srv_pulses - s0, 0);
        chk("idle_cur",    {30'd0, cur_app}, 32'h0);

        // Gap-out: request on 2 at tick 3, home detector idle.
        do_reset();
        s0 = srv_pulses;
        tick1();
        tick1();
        req = 4'b0100;
        tick1();
        req = 4'b0000;
        repeat (6) tick1();
        chk("gap_green_t9",   {28'd0, green},  32'h1);
        tick1();
        chk("gap_yellow_t10", {28'd0, yellow}, 32'h1);
        chk("gap_green_off",  {28'd0, green},  32'h0);
        repeat (4) tick1();
        chk("gap_yellow_t14", {28'd0, yellow}, 32'h1);
        tick1();
        chk("gap_allred_t15", {28'd0, red},    32'hF);
        tick1();
        chk("gap_allred_t16", {28'd0, red},    32'hF);
        tick1();
        chk("gap_green_t17",  {28'd0, green},  32'h4);
        chk("gap_cur",        {30'd0, cur_app}, 32'h2);
        chk("gap_served",     {28'd0, srv_last}, 32'h4);
        chk("gap_served_cnt", srv_pulses - s0, 1);

        // Max-out: home detector held, approach 1 waiting from tick 0.
        do_reset();
        req = 4'b0011;
        repeat (59) tick1();
        chk("max_green_t59",  {28'd0, green},  32'h1);
        tick1();
        chk("max_yellow_t60", {28'd0, yellow}, 32'h1);
        repeat (6) tick1();
        chk("max_allred_t66", {28'd0, red},    32'hF);
        tick1();
        chk("max_green_t67",  {28'd0, green},  32'h2);
        chk("max_cur",        {30'd0, cur_app}, 32'h1);
        req = 4'b0000;

        // Round-robin from owner 1 with 0 (latched during home yellow), 2, 3 waiting.
        req = 4'b1100;
        step();
        req = 4'b0000;
        s0 = srv_pulses;
        run_until_grant(40, nt);
        chk("rr1_ticks", nt, 17);
        chk("rr1_grant", {28'd0, srv_last}, 32'h4);
        chk("rr1_green", {28'd0, green},    32'h4);
        run_until_grant(40, nt);
        chk("rr2_ticks", nt, 17);
        chk("rr2_grant", {28'd0, srv_last}, 32'h8);
        chk("rr2_green", {28'd0, green},    32'h8);
        run_until_grant(40, nt);
        chk("rr3_ticks", nt, 17);
        chk("rr3_grant", {28'd0, srv_last}, 32'h1);
        chk("rr3_green", {28'd0, green},    32'h1);
        run_until_grant(40, nt);
        chk("rr_home_hold", nt, 40);
        chk("rr_pulses",    srv_pulses - s0, 3);

        // Preempt to 3 at green timer 3, then hold beyond max green.
        do_reset();
        repeat (3) tick1();
        emerg_valid = 1'b1;
        emerg_id    = 2'd3;
        step();
        chk("pre_yellow",     {28'd0, yellow}, 32'h1);
        chk("pre_green_off",  {28'd0, green},  32'h0);
        repeat (4) tick1();
        chk("pre_yellow_4",   {28'd0, yellow}, 32'h1);
        tick1();
        chk("pre_allred_5",   {28'd0, red},    32'hF);
        tick1();
        chk("pre_allred_6",   {28'd0, red},    32'hF);
        tick1();
        chk("pre_green_8",    {28'd0, green},  32'h8);
        chk("pre_cur",        {30'd0, cur_app}, 32'h3);
        req = 4'b0010;
        step();
        req = 4'b0000;
        bad = 0;
        repeat (70) begin
            tick1();
            if (green != 4'b1000) bad++;
        end
        chk("pre_hold", bad, 0);
        emerg_valid = 1'b0;
        step();
        chk("pre_release_yellow", {28'd0, yellow}, 32'h8);
        repeat (7) tick1();
        chk("pre_next_green", {28'd0, green},   32'h2);
        chk("pre_next_cur",   {30'd0, cur_app}, 32'h1);

        // Reset during yellow of approach 2 with 0 and 3 still waiting.
        do_reset();
        emerg_valid = 1'b1;
        emerg_id    = 2'd2;
        step();
        repeat (7) tick1();
        chk("rsty_green2", {28'd0, green}, 32'h4);
        emerg_valid = 1'b0;
        req = 4'b1001;
        step();
        req = 4'b0000;
        repeat (10) tick1();
        chk("rsty_yellow2", {28'd0, yellow}, 32'h4);
        rst = 1'b1;
        #1;
        chk("rsty_async_green",  {28'd0, green},   32'h1);
        chk("rsty_async_yellow", {28'd0, yellow},  32'h0);
        chk("rsty_async_red",    {28'd0, red},     32'hE);
        chk("rsty_async_cur",    {30'd0, cur_app}, 32'h0);
        step();
        rst = 1'b0;
        step();
        s0  = srv_pulses;
        bad = 0;
        repeat (30) begin
            tick1();
            if (green != 4'b0001) bad++;
        end
        chk("rsty_pend_dropped", bad, 0);
        chk("rsty_no_grant",     srv_pulses - s0, 0);

        chk("lamp_invariant", inv_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
